// File: rtl/taxi_axis_if.sv
// AXI4-Stream bundle shared by the stream source and sink sides.
// Ports/signals:
//   tdata/tkeep/tstrb/tid/tdest/tuser/tlast/tvalid  source -> sink
//   tready                                          sink -> source
// Modports: src (drives the beat), snk (drives tready).
// The *_EN parameters tell consumers which sideband fields carry meaning.
interface taxi_axis_if #(
  parameter int DATA_W  = 8,
  parameter bit KEEP_EN = (DATA_W > 8),
  parameter int KEEP_W  = (DATA_W + 7) / 8,
  parameter bit STRB_EN = 1'b0,
  parameter bit LAST_EN = 1'b1,
  parameter bit ID_EN   = 1'b0,
  parameter int ID_W    = 8,
  parameter bit DEST_EN = 1'b0,
  parameter int DEST_W  = 8,
  parameter bit USER_EN = 1'b0,
  parameter int USER_W  = 1
) ();

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport src (
    output tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tstrb, tid, tdest, tuser, tlast, tvalid,
    output tready
  );

endinterface

// File: rtl/taxi_axis_broadcast_mask.sv
// AXI4-Stream broadcaster with a per-frame destination mask.
// Each input frame is replicated to the outputs selected by a mask captured
// on the frame's first beat. Every output completes its handshake on its own;
// a beat is retired once all selected outputs have taken it. Frames with an
// empty mask are accepted and dropped. Two-register skid datapath with a
// registered input tready.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   s_axis      input stream (snk)
//   s_mask      destination mask, bit n selects output n (MASK_SRC = 0)
//   m_axis[n]   output streams (src), all fed from one data register
//   stat_frame  one-cycle pulse: first beat with nonzero mask accepted
//   stat_drop   one-cycle pulse: first beat with zero mask accepted
// Parameters:
//   M_COUNT   number of outputs, 1..32
//   MASK_SRC  0 = s_mask port, 1 = s_axis.tdest[M_COUNT-1:0]
module taxi_axis_broadcast_mask #(
  parameter int M_COUNT  = 4,
  parameter int MASK_SRC = 0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  taxi_axis_if.snk                s_axis,
  input  wire logic [M_COUNT-1:0] s_mask,
  taxi_axis_if.src                m_axis[M_COUNT],
  output wire logic               stat_frame,
  output wire logic               stat_drop
);

  localparam int MASK_SRC_PORT  = 0;
  localparam int MASK_SRC_TDEST = 1;

  localparam int DATA_W  = s_axis.DATA_W;
  localparam int KEEP_W  = s_axis.KEEP_W;
  localparam bit KEEP_EN = s_axis.KEEP_EN && m_axis[0].KEEP_EN;
  localparam bit STRB_EN = s_axis.STRB_EN && m_axis[0].STRB_EN;
  localparam bit LAST_EN = s_axis.LAST_EN && m_axis[0].LAST_EN;
  localparam bit ID_EN   = s_axis.ID_EN && m_axis[0].ID_EN;
  localparam int ID_W    = m_axis[0].ID_W;
  localparam bit DEST_EN = s_axis.DEST_EN && m_axis[0].DEST_EN;
  localparam int DEST_W  = m_axis[0].DEST_W;
  localparam bit USER_EN = s_axis.USER_EN && m_axis[0].USER_EN;
  localparam int USER_W  = m_axis[0].USER_W;

  // Elaboration-time configuration checks
  if (M_COUNT < 1 || M_COUNT > 32) begin : g_err_m_count
    $fatal(0, "taxi_axis_broadcast_mask: M_COUNT must be 1..32");
  end
  if (m_axis[0].DATA_W != DATA_W) begin : g_err_data_w
    $fatal(0, "taxi_axis_broadcast_mask: DATA_W mismatch");
  end
  if (m_axis[0].KEEP_W != KEEP_W) begin : g_err_keep_w
    $fatal(0, "taxi_axis_broadcast_mask: KEEP_W mismatch");
  end
  if (MASK_SRC != MASK_SRC_PORT && MASK_SRC != MASK_SRC_TDEST) begin : g_err_mask_src
    $fatal(0, "taxi_axis_broadcast_mask: MASK_SRC must be 0 or 1");
  end
  if (MASK_SRC == MASK_SRC_TDEST && (!s_axis.DEST_EN || s_axis.DEST_W < M_COUNT)) begin : g_err_tdest
    $fatal(0, "taxi_axis_broadcast_mask: MASK_SRC=1 needs DEST_EN and DEST_W >= M_COUNT");
  end

  // Control state (reset)
  logic [M_COUNT-1:0] out_valid_reg, out_valid_next;
  logic               tmp_valid_reg, tmp_valid_next;
  logic [M_COUNT-1:0] tmp_mask_reg, tmp_mask_next;
  logic               in_ready_reg, in_ready_next;
  logic               sof_reg;
  logic [M_COUNT-1:0] frame_mask_reg;
  logic               stat_frame_reg, stat_drop_reg;

  // Datapath (no reset; loads only on store events)
  logic [DATA_W-1:0] out_tdata_reg, tmp_tdata_reg;
  logic [KEEP_W-1:0] out_tkeep_reg, tmp_tkeep_reg;
  logic [KEEP_W-1:0] out_tstrb_reg, tmp_tstrb_reg;
  logic              out_tlast_reg, tmp_tlast_reg;
  logic [ID_W-1:0]   out_tid_reg, tmp_tid_reg;
  logic [DEST_W-1:0] out_tdest_reg, tmp_tdest_reg;
  logic [USER_W-1:0] out_tuser_reg, tmp_tuser_reg;

  logic [M_COUNT-1:0] out_ready;
  logic [M_COUNT-1:0] src_mask;
  logic [M_COUNT-1:0] beat_mask;
  logic               out_free;
  logic               accept;
  logic               in_last;
  logic               store_in_out, store_in_tmp, store_tmp_out;

  // tdest cast both truncates and widens so either source elaborates cleanly
  assign src_mask  = (MASK_SRC == MASK_SRC_TDEST) ? M_COUNT'(s_axis.tdest) : s_mask;
  // Only the first beat of a frame samples the mask; later beats reuse it
  assign beat_mask = sof_reg ? src_mask : frame_mask_reg;
  // Free once every still-pending output is taking its copy this cycle
  assign out_free  = (out_valid_reg & ~out_ready) == '0;
  assign accept    = s_axis.tvalid && in_ready_reg;
  // Without tlast every beat closes its own frame
  assign in_last   = LAST_EN ? s_axis.tlast : 1'b1;

  always_comb begin
    out_valid_next = out_valid_reg & ~out_ready;
    tmp_valid_next = tmp_valid_reg;
    tmp_mask_next  = tmp_mask_reg;
    store_in_out   = 1'b0;
    store_in_tmp   = 1'b0;
    store_tmp_out  = 1'b0;
    in_ready_next  = out_free || (!tmp_valid_reg && (out_valid_reg == '0 || !s_axis.tvalid));

    if (in_ready_reg) begin
      if (out_free) begin
        // A zero mask loads no valid bits, which drops the beat silently
        out_valid_next = {M_COUNT{s_axis.tvalid}} & beat_mask;
        store_in_out   = s_axis.tvalid;
      end else begin
        tmp_valid_next = s_axis.tvalid;
        tmp_mask_next  = beat_mask;
        store_in_tmp   = s_axis.tvalid;
      end
    end else if (out_free) begin
      out_valid_next = {M_COUNT{tmp_valid_reg}} & tmp_mask_reg;
      tmp_valid_next = 1'b0;
      store_tmp_out  = tmp_valid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= '0;
      tmp_valid_reg  <= 1'b0;
      tmp_mask_reg   <= '0;
      in_ready_reg   <= 1'b0;
      sof_reg        <= 1'b1;
      frame_mask_reg <= '0;
      stat_frame_reg <= 1'b0;
      stat_drop_reg  <= 1'b0;
    end else begin
      out_valid_reg  <= out_valid_next;
      tmp_valid_reg  <= tmp_valid_next;
      tmp_mask_reg   <= tmp_mask_next;
      in_ready_reg   <= in_ready_next;
      stat_frame_reg <= accept && sof_reg && (src_mask != '0);
      stat_drop_reg  <= accept && sof_reg && (src_mask == '0);
      if (accept) begin
        sof_reg <= in_last;
        if (sof_reg) begin
          frame_mask_reg <= src_mask;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store_in_out) begin
      out_tdata_reg <= s_axis.tdata;
      out_tkeep_reg <= s_axis.tkeep;
      out_tstrb_reg <= s_axis.tstrb;
      out_tlast_reg <= s_axis.tlast;
      out_tid_reg   <= ID_W'(s_axis.tid);
      out_tdest_reg <= DEST_W'(s_axis.tdest);
      out_tuser_reg <= USER_W'(s_axis.tuser);
    end else if (store_tmp_out) begin
      out_tdata_reg <= tmp_tdata_reg;
      out_tkeep_reg <= tmp_tkeep_reg;
      out_tstrb_reg <= tmp_tstrb_reg;
      out_tlast_reg <= tmp_tlast_reg;
      out_tid_reg   <= tmp_tid_reg;
      out_tdest_reg <= tmp_tdest_reg;
      out_tuser_reg <= tmp_tuser_reg;
    end
    if (store_in_tmp) begin
      tmp_tdata_reg <= s_axis.tdata;
      tmp_tkeep_reg <= s_axis.tkeep;
      tmp_tstrb_reg <= s_axis.tstrb;
      tmp_tlast_reg <= s_axis.tlast;
      tmp_tid_reg   <= ID_W'(s_axis.tid);
      tmp_tdest_reg <= DEST_W'(s_axis.tdest);
      tmp_tuser_reg <= USER_W'(s_axis.tuser);
    end
  end

  logic [KEEP_W-1:0] out_tkeep;
  assign out_tkeep = KEEP_EN ? out_tkeep_reg : {KEEP_W{1'b1}};

  genvar gi;
  for (gi = 0; gi < M_COUNT; gi++) begin : g_out
    assign out_ready[gi]     = m_axis[gi].tready;
    assign m_axis[gi].tvalid = out_valid_reg[gi];
    assign m_axis[gi].tdata  = out_tdata_reg;
    assign m_axis[gi].tkeep  = out_tkeep;
    assign m_axis[gi].tstrb  = STRB_EN ? out_tstrb_reg : out_tkeep;
    assign m_axis[gi].tlast  = LAST_EN ? out_tlast_reg : 1'b1;
    assign m_axis[gi].tid    = ID_EN ? out_tid_reg : '0;
    assign m_axis[gi].tdest  = DEST_EN ? out_tdest_reg : '0;
    assign m_axis[gi].tuser  = USER_EN ? out_tuser_reg : '0;
  end

  assign s_axis.tready = in_ready_reg;
  assign stat_frame    = stat_frame_reg;
  assign stat_drop     = stat_drop_reg;

endmodule

// File: tb/tb_taxi_axis_broadcast_mask.sv
// Self-checking bench for taxi_axis_broadcast_mask.
// Two instances: dut (mask from s_mask) and dut_tdest (mask from tdest).
// Accepted input beats are pushed into per-output expectation queues; every
// presented output beat is compared against the queue head and popped on its
// handshake.
module tb_taxi_axis_broadcast_mask;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  taxi_axis_if #(.DATA_W(16), .DEST_EN(1'b1), .DEST_W(4)) s0_axis ();
  taxi_axis_if #(.DATA_W(16), .DEST_EN(1'b1), .DEST_W(4)) m0_axis[4] ();
  taxi_axis_if #(.DATA_W(16), .DEST_EN(1'b1), .DEST_W(4)) s1_axis ();
  taxi_axis_if #(.DATA_W(16), .DEST_EN(1'b1), .DEST_W(4)) m1_axis[4] ();

  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic [15:0] s0_tdata = '0, s1_tdata = '0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic [3:0]  s0_tdest = '0, s1_tdest = '0;
  logic [3:0]  s0_mask = '0, s1_mask = 4'b1111;
  logic [3:0]  m0_tready = 4'b1111, m1_tready = 4'b1111;
  wire         s0_tready, s1_tready;
  wire  [3:0]  m0_tvalid, m1_tvalid, m0_tlast, m1_tlast;
  wire  [15:0] m0_tdata [4];
  wire  [15:0] m1_tdata [4];
  wire         stat_frame0, stat_drop0, stat_frame1, stat_drop1;

  assign s0_axis.tdata = s0_tdata;   assign s1_axis.tdata = s1_tdata;
  assign s0_axis.tkeep = '1;         assign s1_axis.tkeep = '1;
  assign s0_axis.tstrb = '1;         assign s1_axis.tstrb = '1;
  assign s0_axis.tlast = s0_tlast;   assign s1_axis.tlast = s1_tlast;
  assign s0_axis.tid   = '0;         assign s1_axis.tid   = '0;
  assign s0_axis.tdest = s0_tdest;   assign s1_axis.tdest = s1_tdest;
  assign s0_axis.tuser = '0;         assign s1_axis.tuser = '0;
  assign s0_axis.tvalid = s0_tvalid; assign s1_axis.tvalid = s1_tvalid;
  assign s0_tready = s0_axis.tready; assign s1_tready = s1_axis.tready;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_map
    assign m0_tvalid[gi] = m0_axis[gi].tvalid;
    assign m0_tdata[gi]  = m0_axis[gi].tdata;
    assign m0_tlast[gi]  = m0_axis[gi].tlast;
    assign m0_axis[gi].tready = m0_tready[gi];
    assign m1_tvalid[gi] = m1_axis[gi].tvalid;
    assign m1_tdata[gi]  = m1_axis[gi].tdata;
    assign m1_tlast[gi]  = m1_axis[gi].tlast;
    assign m1_axis[gi].tready = m1_tready[gi];
  end

  taxi_axis_broadcast_mask #(.M_COUNT(4), .MASK_SRC(0)) dut (
    .clk(clk), .rst(rst), .s_axis(s0_axis), .s_mask(s0_mask),
    .m_axis(m0_axis), .stat_frame(stat_frame0), .stat_drop(stat_drop0)
  );

  taxi_axis_broadcast_mask #(.M_COUNT(4), .MASK_SRC(1)) dut_tdest (
    .clk(clk), .rst(rst), .s_axis(s1_axis), .s_mask(s1_mask),
    .m_axis(m1_axis), .stat_frame(stat_frame1), .stat_drop(stat_drop1)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [16:0] exp_q [8][$];
  int          hs_cnt [8];
  bit          model_sof [2] = '{1'b1, 1'b1};
  logic [3:0]  model_mask [2] = '{4'b0, 4'b0};
  bit          acc_flag [2] = '{1'b0, 1'b0};
  int          frame_seen0 = 0, drop_seen0 = 0, frame_exp0 = 0, drop_exp0 = 0;
  int          acc_cyc0 [$];
  int          hs_cyc0 [$];
  logic [15:0] seq = 16'h0100;

  task automatic model_accept(input int d, input logic [15:0] data, input logic last,
                              input logic [3:0] msk);
    if (model_sof[d]) begin
      model_mask[d] = msk;
      if (d == 0) begin
        if (msk != 4'b0) frame_exp0++;
        else drop_exp0++;
      end
    end
    for (int n = 0; n < 4; n++)
      if (model_mask[d][n]) exp_q[d*4+n].push_back({last, data});
    model_sof[d] = last;
    if (d == 0) acc_cyc0.push_back(cyc);
  endtask

  // One clock: score at negedge+1 the handshakes the next posedge will take,
  // then return at posedge+1 so callers change inputs away from the edge.
  task automatic cycle();
    logic [3:0]  mv [2];
    logic [3:0]  mr [2];
    logic [16:0] mb [2][4];
    @(negedge clk);
    #1;
    cyc++;
    mv[0] = m0_tvalid; mv[1] = m1_tvalid;
    mr[0] = m0_tready; mr[1] = m1_tready;
    for (int n = 0; n < 4; n++) begin
      mb[0][n] = {m0_tlast[n], m0_tdata[n]};
      mb[1][n] = {m1_tlast[n], m1_tdata[n]};
    end
    acc_flag[0] = 1'b0;
    acc_flag[1] = 1'b0;
    if (stat_frame0) frame_seen0++;
    if (stat_drop0) drop_seen0++;
    if (rst) begin
      for (int k = 0; k < 8; k++) exp_q[k].delete();
      model_sof[0] = 1'b1;
      model_sof[1] = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int n = 0; n < 4; n++) begin
          if (mv[d][n]) begin
            checks++;
            if (exp_q[d*4+n].size() == 0) begin
              errors++;
              $display("FAIL beat_unexpected dut%0d out%0d: got tvalid with data=%h last=%b, required no tvalid",
                       d, n, mb[d][n][15:0], mb[d][n][16]);
            end else if (mb[d][n] !== exp_q[d*4+n][0]) begin
              errors++;
              $display("FAIL beat_data dut%0d out%0d: got last/data=%h, required %h",
                       d, n, mb[d][n], exp_q[d*4+n][0]);
            end
            if (mr[d][n] && exp_q[d*4+n].size() > 0) begin
              void'(exp_q[d*4+n].pop_front());
              hs_cnt[d*4+n]++;
              if (d == 0 && n == 0) hs_cyc0.push_back(cyc);
            end
          end
        end
      end
      if (s0_tvalid && s0_tready) begin
        acc_flag[0] = 1'b1;
        model_accept(0, s0_tdata, s0_tlast, s0_mask);
      end
      if (s1_tvalid && s1_tready) begin
        acc_flag[1] = 1'b1;
        model_accept(1, s1_tdata, s1_tlast, s1_tdest);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input int d, input logic last, input logic [3:0] msk);
    int t = 0;
    if (d == 0) begin
      s0_tvalid = 1'b1; s0_tdata = seq; s0_tlast = last; s0_mask = msk;
    end else begin
      s1_tvalid = 1'b1; s1_tdata = seq; s1_tlast = last; s1_tdest = msk;
    end
    seq++;
    do begin
      cycle();
      t++;
    end while (!acc_flag[d] && t < 100);
    checks++;
    if (!acc_flag[d]) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: beat not accepted after %0d cycles, required acceptance", d, t);
    end
  endtask

  task automatic drain();
    int left;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    m0_tready = 4'b1111;
    m1_tready = 4'b1111;
    for (int i = 0; i < 100; i++) begin
      left = 0;
      for (int k = 0; k < 8; k++) left += exp_q[k].size();
      if (left == 0) break;
      cycle();
    end
    cycle();
    cycle();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d out%0d: %0d beats never delivered, required 0", k / 4, k % 4, exp_q[k].size());
      end
    end
  endtask

  task automatic check_hs(input string name, input int k, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d out%0d: got %0d beats, required %0d", name, k / 4, k % 4, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cycle();
    checks++;
    if (s0_tready !== 1'b0 || m0_tvalid !== 4'b0 || stat_frame0 !== 1'b0 || stat_drop0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got tready=%b tvalid=%b stat=%b%b, required 0 0000 00",
               s0_tready, m0_tvalid, stat_frame0, stat_drop0);
    end
    checks++;
    if (s1_tready !== 1'b0 || m1_tvalid !== 4'b0) begin
      errors++;
      $display("FAIL reset_state_tdest: got tready=%b tvalid=%b, required 0 0000", s1_tready, m1_tvalid);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (s0_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got tready=%b, required 1", s0_tready);
    end
  endtask

  task automatic test_basic();
    int f0 = frame_seen0;
    int h [8] = hs_cnt;
    acc_cyc0.delete();
    hs_cyc0.delete();
    send_beat(0, 1'b0, 4'b0101);
    send_beat(0, 1'b0, 4'b0101);
    send_beat(0, 1'b1, 4'b0101);
    drain();
    for (int k = 0; k < 4; k++)
      check_hs("basic_count", k, hs_cnt[k] - h[k], (k == 0 || k == 2) ? 3 : 0);
    checks++;
    if (acc_cyc0.size() != 3 || acc_cyc0[2] - acc_cyc0[0] != 2) begin
      errors++;
      $display("FAIL basic_throughput: got %0d accepts spanning %0d cycles, required 3 in 3 cycles",
               acc_cyc0.size(), acc_cyc0.size() == 3 ? acc_cyc0[2] - acc_cyc0[0] + 1 : -1);
    end
    checks++;
    if (hs_cyc0.size() != 3 || acc_cyc0.size() == 0 || hs_cyc0[0] != acc_cyc0[0] + 1 || hs_cyc0[2] != hs_cyc0[0] + 2) begin
      errors++;
      $display("FAIL basic_latency: got first output %0d cycles after accept over %0d beats, required 1 cycle and 3 back-to-back",
               (hs_cyc0.size() > 0 && acc_cyc0.size() > 0) ? hs_cyc0[0] - acc_cyc0[0] : -1, hs_cyc0.size());
    end
    checks++;
    if (frame_seen0 - f0 != 1) begin
      errors++;
      $display("FAIL basic_stat_frame: got %0d pulses, required 1", frame_seen0 - f0);
    end
  endtask

  task automatic test_mask_change();
    int h [8] = hs_cnt;
    send_beat(0, 1'b0, 4'b0011);
    send_beat(0, 1'b0, 4'b1100);
    send_beat(0, 1'b0, 4'b1100);
    send_beat(0, 1'b1, 4'b1100);
    drain();
    for (int k = 0; k < 4; k++)
      check_hs("mask_change_frame1", k, hs_cnt[k] - h[k], (k < 2) ? 4 : 0);
    h = hs_cnt;
    send_beat(0, 1'b0, 4'b1100);
    send_beat(0, 1'b1, 4'b0011);
    drain();
    for (int k = 0; k < 4; k++)
      check_hs("mask_change_frame2", k, hs_cnt[k] - h[k], (k < 2) ? 0 : 2);
  endtask

  task automatic test_drop();
    int f0 = frame_seen0;
    int d0 = drop_seen0;
    int h [8] = hs_cnt;
    acc_cyc0.delete();
    send_beat(0, 1'b0, 4'b0000);
    send_beat(0, 1'b1, 4'b1111);
    checks++;
    if (acc_cyc0.size() != 2 || acc_cyc0[1] - acc_cyc0[0] != 1 || s0_tready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: got %0d accepts, tready=%b, required 2 back-to-back with tready=1",
               acc_cyc0.size(), s0_tready);
    end
    drain();
    for (int k = 0; k < 4; k++) check_hs("drop_outputs", k, hs_cnt[k] - h[k], 0);
    checks++;
    if (drop_seen0 - d0 != 1 || frame_seen0 - f0 != 0) begin
      errors++;
      $display("FAIL drop_stats: got drop=%0d frame=%0d, required drop=1 frame=0",
               drop_seen0 - d0, frame_seen0 - f0);
    end
    h = hs_cnt;
    send_beat(0, 1'b0, 4'b1111);
    send_beat(0, 1'b0, 4'b0000);
    send_beat(0, 1'b1, 4'b0000);
    drain();
    for (int k = 0; k < 4; k++) check_hs("after_drop", k, hs_cnt[k] - h[k], 3);
  endtask

  task automatic test_backpressure();
    int h [8] = hs_cnt;
    int b = 0;
    int stall_acc = 0;
    bit saw_low = 1'b0;
    for (int i = 0; i < 60 && b < 8; i++) begin
      s0_tvalid = 1'b1;
      s0_tdata  = seq;
      s0_tlast  = (b == 7);
      s0_mask   = 4'b1111;
      m0_tready = (i >= 2 && i < 7) ? 4'b0111 : 4'b1111;
      cycle();
      if (acc_flag[0]) begin
        b++;
        seq++;
        if (i >= 2 && i < 7) stall_acc++;
      end
      if (i >= 2 && i < 7 && s0_tready === 1'b0) saw_low = 1'b1;
    end
    drain();
    checks++;
    if (b != 8) begin
      errors++;
      $display("FAIL bp_accept: got %0d beats accepted, required 8", b);
    end
    checks++;
    if (stall_acc > 2 || !saw_low) begin
      errors++;
      $display("FAIL bp_ready: got %0d accepts during stall, tready_low=%b, required <=2 and 1", stall_acc, saw_low);
    end
    for (int k = 0; k < 4; k++) check_hs("bp_count", k, hs_cnt[k] - h[k], 8);
  endtask

  task automatic test_tdest();
    int h [8] = hs_cnt;
    send_beat(1, 1'b0, 4'd2);
    send_beat(1, 1'b0, 4'd8);
    send_beat(1, 1'b1, 4'd8);
    drain();
    for (int k = 4; k < 8; k++) check_hs("tdest_count", k, hs_cnt[k] - h[k], (k == 5) ? 3 : 0);
  endtask

  task automatic test_reset_mid();
    int h [8];
    m0_tready = 4'b0000;
    send_beat(0, 1'b0, 4'b0011);
    s0_tvalid = 1'b0;
    cycle();
    checks++;
    if (m0_tvalid !== 4'b0011) begin
      errors++;
      $display("FAIL mid_pending: got tvalid=%b, required 0011", m0_tvalid);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (m0_tvalid !== 4'b0000 || s0_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got tvalid=%b tready=%b, required 0000 0", m0_tvalid, s0_tready);
    end
    rst = 1'b0;
    m0_tready = 4'b1111;
    cycle();
    h = hs_cnt;
    send_beat(0, 1'b1, 4'b1100);
    drain();
    for (int k = 0; k < 4; k++) check_hs("mid_resample", k, hs_cnt[k] - h[k], (k < 2) ? 0 : 1);
  endtask

  task automatic test_random();
    int beats = 0;
    int it = 0;
    int f0 = frame_seen0, d0 = drop_seen0, fe = frame_exp0, de = drop_exp0;
    s0_tvalid = 1'b0;
    while (beats < 10000 && it < 60000) begin
      if (!s0_tvalid && $urandom_range(3) != 0) begin
        s0_tvalid = 1'b1;
        s0_tdata  = seq;
        seq++;
        s0_tlast  = ($urandom_range(3) == 0);
        s0_mask   = 4'($urandom_range(15));
      end
      m0_tready = 4'($urandom_range(15)) | 4'($urandom_range(15));
      cycle();
      it++;
      if (acc_flag[0]) begin
        beats++;
        s0_tvalid = 1'b0;
      end
    end
    checks++;
    if (beats < 10000) begin
      errors++;
      $display("FAIL random_budget: got %0d beats in %0d cycles, required 10000", beats, it);
    end
    s0_tlast = 1'b1;
    drain();
    checks++;
    if (frame_seen0 - f0 != frame_exp0 - fe || drop_seen0 - d0 != drop_exp0 - de) begin
      errors++;
      $display("FAIL random_stats: got frame=%0d drop=%0d, required frame=%0d drop=%0d",
               frame_seen0 - f0, drop_seen0 - d0, frame_exp0 - fe, drop_exp0 - de);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) hs_cnt[k] = 0;
    test_reset();
    test_basic();
    test_mask_change();
    test_drop();
    test_backpressure();
    test_tdest();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
